// File: rtl/eth_sd_pkg.sv
// rtl/eth_sd_pkg.sv - shared types and constants for the Ethernet->SD sector path
package eth_sd_pkg;

  localparam int SD_SECTOR_BYTES = 512;
  localparam int SD_ADDR_W       = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DATA,
    WAIT_DONE
  } wr_state_t;

endpackage

// File: rtl/eth_sd_sector_writer_if.sv
// rtl/eth_sd_sector_writer_if.sv - FIFO read port and SD write port bundle
interface eth_sd_sector_writer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);

  logic [DATA_W-1:0] fifo_data;
  logic              fifo_vld;
  logic              fifo_rd;
  logic              sd_wr_req;
  logic [ADDR_W-1:0] sd_wr_addr;
  logic              sd_wr_ack;
  logic [DATA_W-1:0] sd_data;
  logic              sd_data_vld;
  logic              sd_data_rdy;
  logic              sd_wr_done;
  logic              sd_wr_err;

  modport master (
    input  fifo_data, fifo_vld, sd_wr_ack, sd_data_rdy, sd_wr_done, sd_wr_err,
    output fifo_rd, sd_wr_req, sd_wr_addr, sd_data, sd_data_vld
  );

  modport slave (
    output fifo_data, fifo_vld, sd_wr_ack, sd_data_rdy, sd_wr_done, sd_wr_err,
    input  fifo_rd, sd_wr_req, sd_wr_addr, sd_data, sd_data_vld
  );

endinterface

// File: rtl/eth_sd_sector_writer.sv
// rtl/eth_sd_sector_writer.sv - frames the prefetch FIFO word stream into SD sector writes
module eth_sd_sector_writer
  import eth_sd_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int SECTOR_WORDS = SD_SECTOR_BYTES / 4,
  parameter int ADDR_W       = SD_ADDR_W,
  parameter bit BYTE_SWAP    = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [ADDR_W-1:0]     start_addr,
  eth_sd_sector_writer_if.master bus,
  output logic                  busy,
  output logic [ADDR_W-1:0]     sector_cnt,
  output logic                  err_flag
);

  localparam int               CNT_W    = $clog2(SECTOR_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SECTOR_WORDS);

  wr_state_t         state_q, state_d;
  logic [CNT_W-1:0]  word_cnt_q;
  logic [DATA_W-1:0] data_q;
  logic              vld_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] sector_cnt_q;
  logic              err_q;
  logic [DATA_W-1:0] swapped;
  logic [ADDR_W-1:0] addr_base;
  logic              pop;

  always_comb begin
    swapped = bus.fifo_data;
    if (BYTE_SWAP) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        swapped[8*b +: 8] = bus.fifo_data[DATA_W-8-8*b +: 8];
      end
    end
  end

  // The first sector after reset takes start_addr live; later sectors use the latched copy.
  assign addr_base = (sector_cnt_q == '0) ? start_addr : base_q;
  assign pop       = bus.fifo_rd & bus.fifo_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (enable && bus.fifo_vld) state_d = REQ;
      REQ:       if (bus.sd_wr_ack) state_d = DATA;
      DATA:      if (word_cnt_q == LAST_CNT && vld_q && bus.sd_data_rdy) state_d = WAIT_DONE;
      WAIT_DONE: if (bus.sd_wr_done) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // fifo_rd deliberately ignores fifo_vld; the pop is the AND of both.
  always_comb begin
    bus.sd_wr_req = (state_q == REQ);
    bus.fifo_rd   = (state_q == DATA) && (word_cnt_q < LAST_CNT) &&
                    (!vld_q || bus.sd_data_rdy);
    busy          = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_q   <= '0;
      data_q       <= '0;
      vld_q        <= 1'b0;
      addr_q       <= '0;
      base_q       <= '0;
      sector_cnt_q <= '0;
      err_q        <= 1'b0;
    end else begin
      if (state_q == IDLE && sector_cnt_q == '0) begin
        base_q <= start_addr;
      end
      if (state_q == IDLE && state_d == REQ) begin
        addr_q <= addr_base + sector_cnt_q;
      end
      if (pop) begin
        data_q     <= swapped;
        vld_q      <= 1'b1;
        word_cnt_q <= word_cnt_q + 1'b1;
      end else if (vld_q && bus.sd_data_rdy) begin
        vld_q <= 1'b0;
      end
      if (state_q == WAIT_DONE && bus.sd_wr_done) begin
        sector_cnt_q <= sector_cnt_q + 1'b1;
        err_q        <= err_q | bus.sd_wr_err;
        word_cnt_q   <= '0;
      end
    end
  end

  assign bus.sd_data     = data_q;
  assign bus.sd_data_vld = vld_q;
  assign bus.sd_wr_addr  = addr_q;
  assign sector_cnt      = sector_cnt_q;
  assign err_flag        = err_q;

endmodule

// File: tb/tb_eth_sd_sector_writer.sv
// tb/tb_eth_sd_sector_writer.sv - bench for eth_sd_sector_writer with FIFO/SD models and scoreboard
module tb_eth_sd_sector_writer;

  localparam int SW  = 128;
  localparam int LIM = 5000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [31:0] start_addr;
  logic        busy;
  logic [31:0] sector_cnt;
  logic        err_flag;

  logic        s_enable;
  logic        s_busy;
  logic [31:0] s_cnt;
  logic        s_err;

  eth_sd_sector_writer_if #(.DATA_W(32), .ADDR_W(32)) bus ();
  eth_sd_sector_writer_if #(.DATA_W(32), .ADDR_W(32)) sbus ();

  eth_sd_sector_writer #(.DATA_W(32), .SECTOR_WORDS(SW), .ADDR_W(32), .BYTE_SWAP(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start_addr(start_addr), .bus(bus),
    .busy(busy), .sector_cnt(sector_cnt), .err_flag(err_flag)
  );

  eth_sd_sector_writer #(.DATA_W(32), .SECTOR_WORDS(SW), .ADDR_W(32), .BYTE_SWAP(1'b1)) dut_swap (
    .clk(clk), .rst_n(rst_n), .enable(s_enable), .start_addr(32'h0), .bus(sbus),
    .busy(s_busy), .sector_cnt(s_cnt), .err_flag(s_err)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] fifo_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] addr_q[$];
  int          gap_pct = 0;
  int          rdy_gap = 0;
  int          cyc = 0;
  int          req_wait = 0;
  int          done_wait = 0;
  int          words_acc = 0;
  int          pops = 0;
  int          first_acc = 0;
  int          last_acc = 0;
  bit          pop_pend = 0;
  bit          hold_pend = 0;
  logic [31:0] hold_val = '0;
  bit          err_next = 0;
  bit          stray = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock of FIFO + SD controller model; handshakes are sampled 1 ns after the negedge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    bus.sd_wr_ack  = 1'b0;
    bus.sd_wr_done = 1'b0;
    bus.sd_wr_err  = 1'b0;
    if (!rst_n) begin
      pop_pend = 0; hold_pend = 0; words_acc = 0; pops = 0; req_wait = 0; done_wait = 0;
      exp_q = fifo_q;
    end else begin
      if (pop_pend) void'(fifo_q.pop_front());
      pop_pend = 0;
      if (bus.sd_wr_req) begin
        req_wait++;
        if (req_wait > 2) begin
          bus.sd_wr_ack = 1'b1;
          req_wait = 0;
          if (addr_q.size() != 0) check("req_addr", bus.sd_wr_addr, addr_q.pop_front());
          else check("req_unexpected", bus.sd_wr_req, 0);
        end
      end
      if (words_acc == SW) begin
        done_wait++;
        if (done_wait > 2) begin
          bus.sd_wr_done = 1'b1;
          bus.sd_wr_err  = err_next;
          err_next = 0; words_acc = 0; pops = 0; done_wait = 0;
        end
      end
      if (stray) begin
        bus.sd_wr_done = 1'b1;
        bus.sd_wr_err  = 1'b1;
        stray = 0;
      end
    end
    bus.fifo_vld    = (fifo_q.size() != 0) && ($urandom_range(0, 99) >= gap_pct);
    bus.fifo_data   = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
    bus.sd_data_rdy = ($urandom_range(0, 99) >= rdy_gap);
    #1;
    if (rst_n) begin
      if (hold_pend) begin
        check("hold_vld", bus.sd_data_vld, 1);
        check("hold_data", bus.sd_data, hold_val);
      end
      hold_pend = bus.sd_data_vld && !bus.sd_data_rdy;
      hold_val  = bus.sd_data;
      if (bus.sd_data_vld && bus.sd_data_rdy) begin
        if (exp_q.size() != 0) check("sd_data", bus.sd_data, exp_q.pop_front());
        else check("data_unexpected", bus.sd_data_vld, 0);
        if (words_acc == 0) first_acc = cyc;
        last_acc = cyc;
        words_acc++;
      end
      if (bus.fifo_rd && bus.fifo_vld) begin
        pop_pend = 1;
        pops++;
        check("pop_le_sector", pops <= SW, 1);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; start_addr = 32'h0;
    bus.fifo_data = '0; bus.fifo_vld = 1'b0; bus.sd_wr_ack = 1'b0; bus.sd_data_rdy = 1'b0;
    bus.sd_wr_done = 1'b0; bus.sd_wr_err = 1'b0;
    s_enable = 1'b0;
    sbus.fifo_data = '0; sbus.fifo_vld = 1'b0; sbus.sd_wr_ack = 1'b0; sbus.sd_data_rdy = 1'b0;
    sbus.sd_wr_done = 1'b0; sbus.sd_wr_err = 1'b0;
    tick(); tick();

    check("rst_fifo_rd", bus.fifo_rd, 0);
    check("rst_req", bus.sd_wr_req, 0);
    check("rst_vld", bus.sd_data_vld, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_flag, 0);
    check("rst_data", bus.sd_data, 0);
    check("rst_addr", bus.sd_wr_addr, 0);
    check("rst_cnt", sector_cnt, 0);

    // Single sector, full throughput.
    start_addr = 32'h100;
    for (int i = 0; i < SW; i++) begin fifo_q.push_back(32'(i)); exp_q.push_back(32'(i)); end
    addr_q.push_back(32'h100);
    rst_n = 1'b1; enable = 1'b1;
    for (int i = 0; i < LIM && sector_cnt != 1; i++) tick();
    check("t1_cnt", sector_cnt, 1);
    check("t1_throughput", last_acc - first_acc, SW - 1);
    check("t1_exp_empty", exp_q.size(), 0);
    check("t1_addr_used", addr_q.size(), 0);
    tick();
    check("t1_busy", busy, 0);

    // Done pulse while idle must be ignored.
    stray = 1;
    tick(); tick();
    check("stray_cnt", sector_cnt, 1);
    check("stray_err", err_flag, 0);

    // Two back-to-back sectors.
    for (int i = SW; i < 3 * SW; i++) begin fifo_q.push_back(32'(i)); exp_q.push_back(32'(i)); end
    addr_q.push_back(32'h101); addr_q.push_back(32'h102);
    for (int i = 0; i < LIM && sector_cnt != 3; i++) tick();
    check("t2_cnt", sector_cnt, 3);
    check("t2_addr_used", addr_q.size(), 0);

    // Random stalls on both sides.
    gap_pct = 50; rdy_gap = 50;
    for (int i = 0; i < SW; i++) begin
      logic [31:0] w;
      w = $urandom;
      fifo_q.push_back(w); exp_q.push_back(w);
    end
    addr_q.push_back(32'h103);
    for (int i = 0; i < LIM && sector_cnt != 4; i++) tick();
    check("t3_cnt", sector_cnt, 4);
    check("t3_exp_empty", exp_q.size(), 0);
    gap_pct = 0; rdy_gap = 0;

    // Failed sector, then a clean one.
    for (int i = 0; i < 2 * SW; i++) begin fifo_q.push_back(32'(1000 + i)); exp_q.push_back(32'(1000 + i)); end
    addr_q.push_back(32'h104); addr_q.push_back(32'h105);
    err_next = 1;
    for (int i = 0; i < LIM && sector_cnt != 5; i++) tick();
    check("t4_cnt", sector_cnt, 5);
    check("t4_err_set", err_flag, 1);
    for (int i = 0; i < LIM && sector_cnt != 6; i++) tick();
    check("t4_cnt2", sector_cnt, 6);
    check("t4_err_sticky", err_flag, 1);
    check("t4_addr_used", addr_q.size(), 0);

    // Enable dropped mid-sector.
    for (int i = 0; i < 2 * SW; i++) begin fifo_q.push_back(32'(5000 + i)); exp_q.push_back(32'(5000 + i)); end
    addr_q.push_back(32'h106);
    for (int i = 0; i < LIM && words_acc < 64; i++) tick();
    enable = 1'b0;
    check("t5_busy_mid", busy, 1);
    for (int i = 0; i < LIM && sector_cnt != 7; i++) tick();
    check("t5_cnt", sector_cnt, 7);
    tick();
    check("t5_busy_after", busy, 0);
    for (int i = 0; i < 20; i++) tick();
    check("t5_no_req", bus.sd_wr_req, 0);
    check("t5_idle", busy, 0);
    check("t5_cnt_hold", sector_cnt, 7);

    // Reset mid-sector.
    addr_q.push_back(32'h107);
    enable = 1'b1;
    for (int i = 0; i < LIM && words_acc < 30; i++) tick();
    check("t6_reached_30", words_acc, 30);
    rst_n = 1'b0;
    #1;
    check("t6_fifo_rd", bus.fifo_rd, 0);
    check("t6_req", bus.sd_wr_req, 0);
    check("t6_vld", bus.sd_data_vld, 0);
    check("t6_busy", busy, 0);
    check("t6_cnt", sector_cnt, 0);
    check("t6_err", err_flag, 0);
    check("t6_data", bus.sd_data, 0);
    check("t6_addr", bus.sd_wr_addr, 0);
    addr_q.delete();
    for (int i = 0; i < SW; i++) fifo_q.push_back(32'(9000 + i));
    start_addr = 32'h200;
    tick(); tick();
    addr_q.push_back(32'h200);
    rst_n = 1'b1;
    for (int i = 0; i < LIM && sector_cnt != 1; i++) tick();
    check("t6_cnt_after", sector_cnt, 1);
    check("t6_addr_used", addr_q.size(), 0);
    check("t6_err_after", err_flag, 0);
    enable = 1'b0;

    // Byte-swapped instance.
    sbus.fifo_data = 32'h11223344; sbus.fifo_vld = 1'b1; s_enable = 1'b1;
    for (int i = 0; i < 20 && !sbus.sd_wr_req; i++) begin @(negedge clk); #1; end
    check("swap_req", sbus.sd_wr_req, 1);
    @(negedge clk); sbus.sd_wr_ack = 1'b1;
    @(negedge clk); sbus.sd_wr_ack = 1'b0;
    for (int i = 0; i < 20 && !sbus.sd_data_vld; i++) begin @(negedge clk); #1; end
    check("swap_vld", sbus.sd_data_vld, 1);
    check("swap_data", sbus.sd_data, 32'h44332211);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
